// File: rtl/ofs_plat_avalon_sink_responder_pkg.sv
// Shared types and constants for the Avalon split-bus read/write sink responder.
// Struct fields are sized for the widest supported instance and truncated at use.
package ofs_plat_avalon_sink_responder_pkg;

    localparam int MAX_ADDR_WIDTH      = 32;
    localparam int MAX_BURST_CNT_WIDTH = 16;

    localparam logic [1:0] OKAY_RESPONSE = 2'b00;

    typedef struct packed {
        logic [MAX_ADDR_WIDTH-1:0]      addr;
        logic [MAX_BURST_CNT_WIDTH-1:0] burstcount;
    } t_rd_cmd;

    typedef logic [0:0] t_rd_state;
    localparam t_rd_state RD_IDLE  = 1'b0;
    localparam t_rd_state RD_BURST = 1'b1;

    typedef logic [0:0] t_wr_state;
    localparam t_wr_state WR_IDLE  = 1'b0;
    localparam t_wr_state WR_BURST = 1'b1;

endpackage

// File: rtl/ofs_plat_avalon_mem_rdwr_sink_responder_if.sv
// Avalon split-bus read/write memory interface; master is the command source,
// slave is the responding memory.
interface ofs_plat_avalon_mem_rdwr_sink_responder_if #(
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned BURST_CNT_WIDTH = 4
);
    logic                       rd_read;
    logic [ADDR_WIDTH-1:0]      rd_address;
    logic [BURST_CNT_WIDTH-1:0] rd_burstcount;
    logic [DATA_WIDTH/8-1:0]    rd_byteenable;
    logic                       rd_waitrequest;
    logic [DATA_WIDTH-1:0]      rd_readdata;
    logic                       rd_readdatavalid;
    logic [1:0]                 rd_response;

    logic                       wr_write;
    logic [ADDR_WIDTH-1:0]      wr_address;
    logic [BURST_CNT_WIDTH-1:0] wr_burstcount;
    logic [DATA_WIDTH-1:0]      wr_writedata;
    logic [DATA_WIDTH/8-1:0]    wr_byteenable;
    logic                       wr_waitrequest;
    logic                       wr_writeresponsevalid;
    logic [1:0]                 wr_response;

    modport master (
        output rd_read, rd_address, rd_burstcount, rd_byteenable,
        input  rd_waitrequest, rd_readdata, rd_readdatavalid, rd_response,
        output wr_write, wr_address, wr_burstcount, wr_writedata, wr_byteenable,
        input  wr_waitrequest, wr_writeresponsevalid, wr_response
    );

    modport slave (
        input  rd_read, rd_address, rd_burstcount, rd_byteenable,
        output rd_waitrequest, rd_readdata, rd_readdatavalid, rd_response,
        input  wr_write, wr_address, wr_burstcount, wr_writedata, wr_byteenable,
        output wr_waitrequest, wr_writeresponsevalid, wr_response
    );

endinterface

// File: rtl/ofs_plat_avalon_sink_responder_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port that
// returns the old word on a same-cycle read/write collision.
module ofs_plat_avalon_sink_responder_ram #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_byteenable,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wr_byteenable[b]) begin
                    ram[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= ram[rd_addr];
        end
    end

endmodule

// File: rtl/ofs_plat_avalon_mem_rdwr_sink_responder.sv
// Memory endpoint for the sink side of the Avalon split-bus read/write protocol:
// queued read bursts with a fixed-latency return pipe, and burst writes with one response each.
module ofs_plat_avalon_mem_rdwr_sink_responder
    import ofs_plat_avalon_sink_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH        = 10,
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned BURST_CNT_WIDTH   = 4,
    parameter int unsigned RD_CMD_FIFO_DEPTH = 4,
    parameter int unsigned RD_LATENCY        = 2
) (
    input logic clk,
    input logic reset,
    ofs_plat_avalon_mem_rdwr_sink_responder_if.slave mem
);

    localparam int unsigned PTR_W = (RD_CMD_FIFO_DEPTH > 1) ? $clog2(RD_CMD_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RD_CMD_FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RD_CMD_FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RD_CMD_FIFO_DEPTH);
    localparam logic [BURST_CNT_WIDTH-1:0] ONE_BEAT  = BURST_CNT_WIDTH'(1);
    localparam logic [BURST_CNT_WIDTH-1:0] MAX_BURST = BURST_CNT_WIDTH'(2 ** (BURST_CNT_WIDTH - 1));

    // ---------------- read command FIFO ----------------
    t_rd_cmd          cmd_mem [RD_CMD_FIFO_DEPTH];
    logic [PTR_W-1:0] cmd_wr_ptr_q, cmd_rd_ptr_q;
    logic [CNT_W-1:0] cmd_cnt_q;
    logic             cmd_push, cmd_pop, cmd_empty;
    t_rd_cmd          cmd_head;

    assign mem.rd_waitrequest = reset || (cmd_cnt_q == FULL_CNT);
    assign cmd_push  = mem.rd_read && !mem.rd_waitrequest;
    assign cmd_empty = (cmd_cnt_q == '0);
    assign cmd_head  = cmd_mem[cmd_rd_ptr_q];

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr_q] <= '{addr:       MAX_ADDR_WIDTH'(mem.rd_address),
                                       burstcount: MAX_BURST_CNT_WIDTH'(mem.rd_burstcount)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            cmd_cnt_q    <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr_q <= (cmd_wr_ptr_q == LAST_PTR) ? '0 : cmd_wr_ptr_q + 1'b1;
            if (cmd_pop)  cmd_rd_ptr_q <= (cmd_rd_ptr_q == LAST_PTR) ? '0 : cmd_rd_ptr_q + 1'b1;
            if (cmd_push && !cmd_pop) begin
                cmd_cnt_q <= cmd_cnt_q + 1'b1;
            end else if (!cmd_push && cmd_pop) begin
                cmd_cnt_q <= cmd_cnt_q - 1'b1;
            end
        end
    end

    // ---------------- read FSM ----------------
    t_rd_state                  rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0]      rd_addr_q, rd_addr_d;
    logic [BURST_CNT_WIDTH-1:0] rd_rem_q, rd_rem_d, head_len;
    logic                       rd_issue;

    // A zero burstcount is illegal; treat it as a single beat so the FSM cannot stall.
    assign head_len = (cmd_head.burstcount[BURST_CNT_WIDTH-1:0] == '0) ?
                      ONE_BEAT : cmd_head.burstcount[BURST_CNT_WIDTH-1:0];

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_rem_d   = rd_rem_q;
        cmd_pop    = 1'b0;
        rd_issue   = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop    = 1'b1;
                    rd_addr_d  = cmd_head.addr[ADDR_WIDTH-1:0];
                    rd_rem_d   = head_len;
                    rd_state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                rd_issue  = 1'b1;
                rd_addr_d = rd_addr_q + 1'b1;
                rd_rem_d  = rd_rem_q - 1'b1;
                if (rd_rem_q == ONE_BEAT) begin
                    if (!cmd_empty) begin
                        cmd_pop   = 1'b1;
                        rd_addr_d = cmd_head.addr[ADDR_WIDTH-1:0];
                        rd_rem_d  = head_len;
                    end else begin
                        rd_state_d = RD_IDLE;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // ---------------- write FSM ----------------
    t_wr_state                  wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d, wr_ram_addr;
    logic [BURST_CNT_WIDTH-1:0] wr_rem_q, wr_rem_d;
    logic                       wr_accept, wr_resp_d, wr_resp_q;

    assign mem.wr_waitrequest = reset;
    assign wr_accept = mem.wr_write && !reset;

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_addr_d   = wr_addr_q;
        wr_rem_d    = wr_rem_q;
        wr_ram_addr = wr_addr_q;
        wr_resp_d   = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                wr_ram_addr = mem.wr_address;
                if (wr_accept) begin
                    if (mem.wr_burstcount <= ONE_BEAT) begin
                        wr_resp_d = 1'b1;
                    end else begin
                        wr_addr_d  = mem.wr_address + 1'b1;
                        wr_rem_d   = mem.wr_burstcount - 1'b1;
                        wr_state_d = WR_BURST;
                    end
                end
            end
            WR_BURST: begin
                if (wr_accept) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_rem_d  = wr_rem_q - 1'b1;
                    if (wr_rem_q == ONE_BEAT) begin
                        wr_resp_d  = 1'b1;
                        wr_state_d = WR_IDLE;
                    end
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    logic [RD_LATENCY-1:0] rd_vld_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q <= RD_IDLE;
            rd_addr_q  <= '0;
            rd_rem_q   <= '0;
            wr_state_q <= WR_IDLE;
            wr_addr_q  <= '0;
            wr_rem_q   <= '0;
            wr_resp_q  <= 1'b0;
            rd_vld_q   <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_addr_q   <= rd_addr_d;
            rd_rem_q    <= rd_rem_d;
            wr_state_q  <= wr_state_d;
            wr_addr_q   <= wr_addr_d;
            wr_rem_q    <= wr_rem_d;
            wr_resp_q   <= wr_resp_d;
            rd_vld_q[0] <= rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
            end
        end
    end

    // ---------------- RAM and read return pipe ----------------
    logic [DATA_WIDTH-1:0] ram_rd_data, beat_data;

    ofs_plat_avalon_sink_responder_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) ram (
        .clk           (clk),
        .wr_en         (wr_accept),
        .wr_addr       (wr_ram_addr),
        .wr_data       (mem.wr_writedata),
        .wr_byteenable (mem.wr_byteenable),
        .rd_en         (rd_issue),
        .rd_addr       (rd_addr_q),
        .rd_data       (ram_rd_data)
    );

    // The RAM output register is the first latency stage.
    if (RD_LATENCY == 1) begin : g_lat1
        assign beat_data = ram_rd_data;
    end else begin : g_latn
        logic [DATA_WIDTH-1:0] data_sr [RD_LATENCY-1];
        always_ff @(posedge clk) begin
            data_sr[0] <= ram_rd_data;
            for (int i = 1; i < RD_LATENCY - 1; i++) begin
                data_sr[i] <= data_sr[i-1];
            end
        end
        assign beat_data = data_sr[RD_LATENCY-2];
    end

    assign mem.rd_readdatavalid      = rd_vld_q[RD_LATENCY-1];
    assign mem.rd_readdata           = rd_vld_q[RD_LATENCY-1] ? beat_data : '0;
    assign mem.rd_response           = OKAY_RESPONSE;
    assign mem.wr_writeresponsevalid = wr_resp_q;
    assign mem.wr_response           = OKAY_RESPONSE;

    logic unused_bits;
    assign unused_bits = ^{cmd_head.addr[MAX_ADDR_WIDTH-1:ADDR_WIDTH],
                           cmd_head.burstcount[MAX_BURST_CNT_WIDTH-1:BURST_CNT_WIDTH],
                           mem.rd_byteenable};

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            assert (mem.rd_burstcount != '0 && mem.rd_burstcount <= MAX_BURST)
            else $fatal(1, "illegal rd_burstcount %0d", mem.rd_burstcount);
        end
        if (wr_accept && wr_state_q == WR_IDLE) begin
            assert (mem.wr_burstcount != '0 && mem.wr_burstcount <= MAX_BURST)
            else $fatal(1, "illegal wr_burstcount %0d", mem.wr_burstcount);
        end
    end
`endif

endmodule
